// File: rtl/ads_pkg.sv
// Shared types and widths for the ADS dual-channel SAR ADC conversion controller.
package ads_pkg;

    localparam int ADS_TAG_W  = 2;
    localparam int ADS_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        WAIT    = 3'd2,
        RDSTART = 3'd3,
        SHIFT   = 3'd4,
        DONE    = 3'd5
    } ads_state_t;

endpackage

// File: rtl/ads_sclk_gen.sv
// ADS serial clock divider: ADS_CLK toggles every CLK_DIV sys_clk cycles while enabled,
// with single-cycle strobes marking the cycle before each rising / falling edge.
module ads_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    // Disabling parks the divider at 0 with ADS_CLK low, so every frame starts with a rise.
    always_comb begin
        wrap   = en && (div_q == DIV_LAST);
        div_d  = '0;
        sclk_d = 1'b0;
        if (en) begin
            div_d  = wrap ? '0 : div_q + DIV_W'(1);
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk      = sclk_q;
    assign sclk_rise = wrap && !sclk_q;
    assign sclk_fall = wrap && sclk_q;

endmodule

// File: rtl/ads_conv_ctrl.sv
// ADS conversion controller: CONVST pulse, BUSY wait with timeout, one serial read frame of
// SDOA/SDOB and a one-cycle data_valid. Optional `ADS_TAG_CHECK_EN adds a sticky tag_err output.
module ads_conv_ctrl
    import ads_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CONVST_W = 2,
    parameter int MIN_CONV = 8,
    parameter int BUSY_TO  = 255,
    parameter int NBITS    = 18
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  conv_req,
    input  logic [1:0]            mode,
    output logic                  ctrl_busy,
    output logic                  req_drop,
    output logic                  err_timeout,
    output logic                  data_valid,
    output logic [ADS_DATA_W-1:0] data_a,
    output logic [ADS_DATA_W-1:0] data_b,
    output logic [ADS_TAG_W-1:0]  tag_a,
    output logic [ADS_TAG_W-1:0]  tag_b,
`ifdef ADS_TAG_CHECK_EN
    output logic                  tag_err,
`endif
    output logic                  ADS_CONVST,
    input  logic                  ADS_BUSY,
    output logic                  ADS_CS_N,
    output logic                  ADS_RD,
    output logic                  ADS_CLK,
    output logic                  ADS_SDI,
    input  logic                  ADS_SDOA,
    input  logic                  ADS_SDOB,
    output logic [1:0]            ADS_M
);

    localparam int CNT_W = $clog2(CONVST_W + MIN_CONV + BUSY_TO + 1);
    localparam int BIT_W = $clog2(NBITS + 1);

    ads_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] sr_a_q, sr_a_d, sr_b_q, sr_b_d;
    logic [ADS_DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [ADS_TAG_W-1:0]  tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [1:0] mode_q, mode_d;
    logic busy_meta_q, busy_sync_q;
    logic data_valid_q, data_valid_d, req_drop_q, req_drop_d, err_timeout_q, err_timeout_d;
    logic sclk_en, sclk, sclk_rise, sclk_fall;
    logic timeout;

    ads_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .en        (sclk_en),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // BUSY is first looked at once MIN_CONV cycles of WAIT have elapsed.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            IDLE:    if (conv_req) state_d = CONV;
            CONV:    if (cnt_q == CNT_W'(CONVST_W - 1)) state_d = WAIT;
            WAIT: begin
                if (cnt_q >= CNT_W'(MIN_CONV)) begin
                    if (!busy_sync_q) begin
                        state_d = RDSTART;
                    end else if (cnt_q == CNT_W'(MIN_CONV + BUSY_TO - 1)) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RDSTART: if (sclk_fall) state_d = SHIFT;
            SHIFT:   if (sclk_fall && (bit_cnt_q == BIT_W'(NBITS))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ADS_CONVST = (state_q == CONV);
        ADS_RD     = (state_q == RDSTART);
        ADS_CS_N   = !((state_q == RDSTART) || (state_q == SHIFT));
        sclk_en    = (state_q == RDSTART) || (state_q == SHIFT);
        ctrl_busy  = (state_q != IDLE);
    end

    // Rises in SHIFT count bits presented by the ADC; the following fall samples them.
    always_comb begin
        cnt_d = '0;
        if (((state_q == CONV) || (state_q == WAIT)) && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        bit_cnt_d = (state_q == SHIFT) ? bit_cnt_q + BIT_W'(sclk_rise) : '0;
        sr_a_d = sr_a_q;
        sr_b_d = sr_b_q;
        if ((state_q == SHIFT) && sclk_fall) begin
            sr_a_d = {sr_a_q[NBITS-2:0], ADS_SDOA};
            sr_b_d = {sr_b_q[NBITS-2:0], ADS_SDOB};
        end
        mode_d        = ((state_q == IDLE) && conv_req) ? mode : mode_q;
        req_drop_d    = conv_req && (state_q != IDLE);
        err_timeout_d = timeout;
        data_valid_d  = (state_q == DONE);
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        tag_a_d  = tag_a_q;
        tag_b_d  = tag_b_q;
        if (state_q == DONE) begin
            data_a_d = sr_a_q[ADS_DATA_W-1:0];
            data_b_d = sr_b_q[ADS_DATA_W-1:0];
            tag_a_d  = sr_a_q[NBITS-1 -: ADS_TAG_W];
            tag_b_d  = sr_b_q[NBITS-1 -: ADS_TAG_W];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            sr_a_q        <= '0;
            sr_b_q        <= '0;
            mode_q        <= '0;
            busy_meta_q   <= 1'b0;
            busy_sync_q   <= 1'b0;
            req_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            data_valid_q  <= 1'b0;
            data_a_q      <= '0;
            data_b_q      <= '0;
            tag_a_q       <= '0;
            tag_b_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_a_q        <= sr_a_d;
            sr_b_q        <= sr_b_d;
            mode_q        <= mode_d;
            busy_meta_q   <= ADS_BUSY;
            busy_sync_q   <= busy_meta_q;
            req_drop_q    <= req_drop_d;
            err_timeout_q <= err_timeout_d;
            data_valid_q  <= data_valid_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            tag_a_q       <= tag_a_d;
            tag_b_q       <= tag_b_d;
        end
    end

`ifdef ADS_TAG_CHECK_EN
    logic [ADS_TAG_W-1:0] exp_tag_q, exp_tag_d;
    logic                 tag_err_q, tag_err_d;

    // After a mismatch the expectation follows the received tag, so one bad frame flags once.
    always_comb begin
        exp_tag_d = exp_tag_q;
        tag_err_d = tag_err_q;
        if (state_q == DONE) begin
            if ((sr_a_q[NBITS-1 -: ADS_TAG_W] != exp_tag_q) ||
                (sr_b_q[NBITS-1 -: ADS_TAG_W] != exp_tag_q)) begin
                tag_err_d = 1'b1;
            end
            exp_tag_d = sr_a_q[NBITS-1 -: ADS_TAG_W] + ADS_TAG_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exp_tag_q <= '0;
            tag_err_q <= 1'b0;
        end else begin
            exp_tag_q <= exp_tag_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err = tag_err_q;
`endif

    assign ADS_CLK     = sclk;
    assign ADS_SDI     = 1'b0;
    assign ADS_M       = mode_q;
    assign req_drop    = req_drop_q;
    assign err_timeout = err_timeout_q;
    assign data_valid  = data_valid_q;
    assign data_a      = data_a_q;
    assign data_b      = data_b_q;
    assign tag_a       = tag_a_q;
    assign tag_b       = tag_b_q;

endmodule
